// File: rtl/pool2_layer.sv
// pool2_layer: 2x2 / stride-2 pooling over a channel-major raster blob stream, with a show-ahead output FIFO.
// Build option: define POOL2_AVG_EN for average pooling; the default build performs max pooling.
module pool2_layer #(
  parameter int W_IN       = 8,
  parameter int H_IN       = 8,
  parameter int C_IN       = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] blob_din,
  input  logic          blob_din_en,
  input  logic          blob_din_eop,
  output logic          blob_din_rdy,
  output logic [DW-1:0] blob_dout,
  output logic          blob_dout_en,
  output logic          blob_dout_eop,
  input  logic          blob_dout_rdy,
  output logic          frame_err
);

  localparam int CW    = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int RW    = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int CHW   = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int LW    = W_IN / 2;
  localparam int LAW   = (LW > 1) ? $clog2(LW) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OUT_N = (W_IN / 2) * (H_IN / 2) * C_IN;
  localparam int OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
`ifdef POOL2_AVG_EN
  localparam int LBW   = DW + 1;
`else
  localparam int LBW   = DW;
`endif

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [DW-1:0]  hold_q;
  logic [LBW-1:0] lbuf_q [LW];
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic [OW-1:0]  ocnt_q;
  logic           rdy_q;
  logic           err_q;

  logic           accept_s;
  logic           col_last_s, row_last_s, ch_last_s, frame_last_s;
  logic [LAW-1:0] lidx_s;
  logic [LBW-1:0] lb_rd_s;
  logic [LBW-1:0] pair_s;
  logic [DW-1:0]  result_s;
  logic           push_s, pop_s, empty_s;

  assign accept_s     = blob_din_en & rdy_q;
  assign col_last_s   = (col_q == CW'(W_IN - 1));
  assign row_last_s   = (row_q == RW'(H_IN - 1));
  assign ch_last_s    = (ch_q == CHW'(C_IN - 1));
  assign frame_last_s = col_last_s & row_last_s & ch_last_s;
  assign lidx_s       = LAW'(col_q >> 1);
  assign lb_rd_s      = lbuf_q[lidx_s];
  assign push_s       = accept_s & col_q[0] & row_q[0];
  assign empty_s      = (cnt_q == '0);
  assign pop_s        = ~empty_s & blob_dout_rdy;

`ifdef POOL2_AVG_EN
  logic [DW+1:0] sum4_s;

  // Pair sums keep one guard bit; the 4-pixel sum keeps two, then floors by arithmetic shift.
  assign pair_s   = {hold_q[DW-1], hold_q} + {blob_din[DW-1], blob_din};
  assign sum4_s   = {lb_rd_s[LBW-1], lb_rd_s} + {pair_s[LBW-1], pair_s};
  assign result_s = DW'($signed(sum4_s) >>> 2);
`else
  assign pair_s   = ($signed(hold_q) > $signed(blob_din)) ? hold_q : blob_din;
  assign result_s = ($signed(lb_rd_s) > $signed(pair_s)) ? lb_rd_s : pair_s;
`endif

  // Position counters: column innermost, then row, then channel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (accept_s) begin
      if (col_last_s) begin
        col_d = '0;
        if (row_last_s) begin
          row_d = '0;
          if (ch_last_s) begin
            ch_d = '0;
          end else begin
            ch_d = ch_q + CHW'(1);
          end
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q    <= '0;
      row_q    <= '0;
      ch_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ocnt_q   <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
      cnt_q <= cnt_d;
      // Ready reflects the post-update occupancy so one in-flight push always has room.
      rdy_q <= (cnt_d <= (AW+1)'(FIFO_DEPTH - 2));
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (ocnt_q == OW'(OUT_N - 1)) begin
          ocnt_q <= '0;
        end else begin
          ocnt_q <= ocnt_q + OW'(1);
        end
      end
      if (accept_s && (blob_din_eop != frame_last_s)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Datapath storage needs no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      if (!col_q[0]) begin
        hold_q <= blob_din;
      end else if (!row_q[0]) begin
        lbuf_q[lidx_s] <= pair_s;
      end
    end
    if (push_s) begin
      mem_q[wr_ptr_q] <= result_s;
    end
  end

  assign blob_din_rdy  = rdy_q;
  assign blob_dout     = empty_s ? '0 : mem_q[rd_ptr_q];
  assign blob_dout_en  = pop_s;
  assign blob_dout_eop = pop_s & (ocnt_q == OW'(OUT_N - 1));
  assign frame_err     = err_q;

endmodule

// File: tb/tb_pool2_layer.sv
// Directed/random bench for pool2_layer against a frame-level pooling reference model.
module tb_pool2_layer;
  localparam int NPIX = 512;
  localparam int NOUT = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] blob_din;
  logic        blob_din_en, blob_din_eop, blob_din_rdy;
  logic [15:0] blob_dout;
  logic        blob_dout_en, blob_dout_eop, blob_dout_rdy;
  logic        frame_err;

  int          n_pass = 0;
  int          n_chk  = 0;
  int          n_out  = 0;
  int          n_eop  = 0;
  bit          mon_en = 1'b0;
  bit          rnd_rdy = 1'b0;
  logic [15:0] frame [NPIX];
  logic [15:0] expq [$];
  bit          eopq [$];

  always #5 clk = ~clk;

  pool2_layer dut (
    .clk(clk), .rst(rst),
    .blob_din(blob_din), .blob_din_en(blob_din_en), .blob_din_eop(blob_din_eop),
    .blob_din_rdy(blob_din_rdy),
    .blob_dout(blob_dout), .blob_dout_en(blob_dout_en), .blob_dout_eop(blob_dout_eop),
    .blob_dout_rdy(blob_dout_rdy), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference pooling of one 2x2 window, straight from the arithmetic definition.
  function automatic logic [15:0] pool4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
`ifdef POOL2_AVG_EN
    int s;
    int q;
    s = $signed(a) + $signed(b) + $signed(c) + $signed(d);
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q[15:0];
`else
    logic signed [15:0] m;
    m = a;
    if ($signed(b) > m) m = b;
    if ($signed(c) > m) m = c;
    if ($signed(d) > m) m = d;
    return m;
`endif
  endfunction

  task automatic model_frame();
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          int b;
          b = c * 64 + 2 * i * 8 + 2 * j;
          expq.push_back(pool4(frame[b], frame[b+1], frame[b+8], frame[b+9]));
          eopq.push_back((c == 7) && (i == 3) && (j == 3));
        end
  endtask

  // Called at a negedge; returns at the negedge after the pixel was accepted.
  task automatic send(input logic [15:0] d, input logic e, input bit gaps);
    int g;
    g = 0;
    if (gaps && ($urandom_range(0, 2) == 0)) @(negedge clk);
    while (!blob_din_rdy) begin
      @(negedge clk);
      g++;
      if (g > 5000) begin
        $display("FAIL send_timeout: observed rdy low for %0d cycles, required < 5000", g);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "input stalled");
      end
    end
    blob_din = d;
    blob_din_eop = e;
    blob_din_en = 1'b1;
    @(negedge clk);
    blob_din_en = 1'b0;
    blob_din_eop = 1'b0;
  endtask

  task automatic send_frame(input int from, input int upto, input int eop_at, input bit gaps);
    for (int k = from; k <= upto; k++) send(frame[k], k == eop_at, gaps);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((expq.size() != 0) && (g < 4000)) begin
      @(negedge clk);
      g++;
    end
    chk(tag, expq.size(), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    blob_din_en = 1'b0;
    @(posedge clk); #1;
    expq.delete();
    eopq.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy0"}, blob_din_rdy, 0);
    chk({tag, "_dout_en0"}, blob_dout_en, 0);
    chk({tag, "_dout_eop0"}, blob_dout_eop, 0);
    chk({tag, "_dout0"}, blob_dout, 0);
    chk({tag, "_err0"}, frame_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rdy1"}, blob_din_rdy, 1);
  endtask

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      blob_dout_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: each transfer is checked against the model queue in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (blob_dout_en) begin
        chk("out_rdy_high", blob_dout_rdy, 1);
        chk("out_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          chk("out_data", blob_dout, expq.pop_front());
          chk("out_eop", blob_dout_eop, eopq.pop_front());
        end
        n_out++;
        if (blob_dout_eop) n_eop++;
      end else begin
        chk("eop_idle", blob_dout_eop, 0);
      end
    end
  end

  initial begin
    int o0, e0, k;
    rst = 1'b0;
    blob_din = '0;
    blob_din_en = 1'b0;
    blob_din_eop = 1'b0;
    blob_dout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset("rst0");

    // T1 ramp frame with latency check on the first output
    @(posedge clk); #1 blob_dout_rdy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) frame[i] = 16'(i);
    model_frame();
    o0 = n_out; e0 = n_eop;
    for (int i = 0; i < NPIX; i++) begin
      send(frame[i], i == NPIX - 1, 1'b0);
      if (i == 8) chk("t1_no_out_before_10", blob_dout_en, 0);
      if (i == 9) begin
        chk("t1_first_out_en", blob_dout_en, 1);
        chk("t1_first_out", blob_dout, 16'd9);
      end
    end
    drain("t1_drain");
    chk("t1_outputs", n_out - o0, NOUT);
    chk("t1_eops", n_eop - e0, 1);
    chk("t1_err", frame_err, 0);

    // T2 signed window in channel 0, rest random
    for (int i = 0; i < NPIX; i++) frame[i] = 16'($urandom);
    frame[0] = -16'sd5; frame[1] = -16'sd3; frame[8] = -16'sd7; frame[9] = -16'sd100;
    model_frame();
    send_frame(0, NPIX - 1, NPIX - 1, 1'b0);
    drain("t2_drain");

    // T3 backpressure: ready drops once seven results are buffered
    @(posedge clk); #1 blob_dout_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) frame[i] = 16'(i);
    model_frame();
    k = 0;
    while ((k < NPIX) && blob_din_rdy) begin
      send(frame[k], k == NPIX - 1, 1'b0);
      k++;
    end
    chk("t3_stall_point", k, 30);
    repeat (200) @(negedge clk);
    chk("t3_rdy_held_low", blob_din_rdy, 0);
    chk("t3_no_out_stalled", blob_dout_en, 0);
    @(posedge clk); #1 blob_dout_rdy = 1'b1;
    @(negedge clk);
    send_frame(k, NPIX - 1, NPIX - 1, 1'b0);
    drain("t3_drain");

    // T4 three back-to-back random frames with random gaps and downstream stalls
    rnd_rdy = 1'b1;
    o0 = n_out; e0 = n_eop;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) frame[i] = 16'($urandom);
      model_frame();
      send_frame(0, NPIX - 1, NPIX - 1, 1'b1);
    end
    drain("t4_drain");
    rnd_rdy = 1'b0;
    @(posedge clk); #1 blob_dout_rdy = 1'b1;
    @(negedge clk);
    chk("t4_outputs", n_out - o0, 3 * NOUT);
    chk("t4_eops", n_eop - e0, 3);
    chk("t4_err", frame_err, 0);

    // T5 early eop: sticky error, cleared only by reset
    for (int i = 0; i < NPIX; i++) frame[i] = 16'($urandom);
    model_frame();
    send_frame(0, 62, 62, 1'b0);
    chk("t5_err_set", frame_err, 1);
    send_frame(63, NPIX - 1, 62, 1'b0);
    drain("t5_drain");
    chk("t5_err_sticky", frame_err, 1);
    apply_reset("t5_rst");

    // T6 reset in the middle of a frame, then a clean ramp frame
    @(posedge clk); #1 blob_dout_rdy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) frame[i] = 16'($urandom);
    model_frame();
    send_frame(0, 99, NPIX - 1, 1'b0);
    apply_reset("t6_rst");
    for (int i = 0; i < NPIX; i++) frame[i] = 16'(i);
    model_frame();
    o0 = n_out; e0 = n_eop;
    send_frame(0, NPIX - 1, NPIX - 1, 1'b0);
    drain("t6_drain");
    chk("t6_outputs", n_out - o0, NOUT);
    chk("t6_eops", n_eop - e0, 1);
    chk("t6_err", frame_err, 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
